riscv_mini_sequencer: RTL
=========================

# riscv_mini_sequencer

Program-feeding front end for the 8-bit RISC-V mini core. It accepts a short program byte-wise over a valid/ready load port and stores it in an internal instruction buffer. On `start` it replays the program to the core's 16-bit instruction port, one instruction per cycle. It captures the core's 8-bit result for every issued instruction, so a test harness or host controller can run the core without driving all 16 instruction pins every cycle.

## Interface
Parameters:
- `DEPTH`, 8: number of 16-bit instruction slots; power of two, 2..16.
- `WIDTH`, 8: result width; matches the core datapath width.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `load_valid` in 1: `load_byte` is valid this cycle.
- `load_byte` in 8: program byte; low byte of an instruction first, then high byte.
- `load_ready` out 1: sequencer can accept a load byte.
- `load_clear` in 1: discard the stored program (synchronous).
- `start` in 1: begin replaying the stored program.
- `busy` out 1: run in progress.
- `done` out 1: one-cycle pulse when the last result is captured.
- `prog_len` out $clog2(DEPTH)+1: number of complete instructions stored.
- `instr` out 16: instruction to the core; `instr[7:0]` goes to core `ui_in`, `instr[15:8]` goes to core `uio_in`.
- `instr_valid` out 1: `instr` is being executed this cycle.
- `result_in` in WIDTH: core result (`uo_out`), combinational from `instr`.
- `result_out` out WIDTH: captured result.
- `result_valid` out 1: `result_out` updated this cycle.
- `checksum` out WIDTH: XOR of all captured results of the current run (see Configuration).

## Operation
- States: IDLE, RUN, FLUSH. Reset sets state to IDLE.
- Reset values: all outputs 0, except `load_ready`, which is 1.
- Reset clears the write pointer, the half-word flag, `prog_len`, `pc`, and `checksum`. Buffer contents are don't-care.

Loading (IDLE only):
- A byte transfers when `load_valid && load_ready`.
- The first byte of a pair goes into a low-byte holding register and sets a `half` flag.
- The second byte writes `{load_byte, low}` to `mem[wptr]`, increments `wptr` and `prog_len`, and clears `half`.
- `load_ready` = (state==IDLE) && (`prog_len` < DEPTH).
- When the buffer is full, further bytes are not accepted (`load_valid` is ignored).
- `load_clear` in IDLE zeroes `wptr`, `prog_len` and `half`. It takes priority over a same-cycle load byte. It is ignored outside IDLE.

Run:
- `start` is accepted only in IDLE with `prog_len` > 0 and `half` == 0. Otherwise it is ignored with no side effects.
- If `start` and a load transfer occur in the same cycle, the load completes first and `start` is ignored.
- At the accept edge: state→RUN, `instr`←`mem[0]`, `instr_valid`←1, `pc`←1, `busy`←1, `checksum`←0.
- Each RUN edge:
  - `result_out`←`result_in`, `result_valid`←1, and `checksum` is updated.
  - If `pc` < `prog_len`: `instr`←`mem[pc]`, `pc`++.
  - Else: `instr_valid`←0, `instr`←0, state→FLUSH.
- FLUSH is one cycle: `result_valid`, `done` and `busy` drop at the next edge, and state→IDLE.
- The program is retained after a run, so `start` can replay it unchanged.
- `rst` mid-run returns the block to IDLE immediately and asynchronously. `instr_valid`, `result_valid`, `busy` and `done` go to 0, and the program is lost (`prog_len` = 0).

## Timing
- Issue rate: one instruction per cycle, with no gaps, for `prog_len` consecutive cycles.
- Result latency: `result_valid`/`result_out` for instruction k appear the cycle after `instr_valid` presents instruction k. Register writes inside the core land on the same edge.
- `done` is asserted together with the final `result_valid` cycle (the FLUSH state).
- `busy` is high from the cycle after `start` is accepted through the FLUSH cycle inclusive.
- Total: `prog_len` + 1 cycles from `start` acceptance to the `done` cycle.
- Load throughput: one byte per cycle while `load_ready` is high.

## Configuration
- Macro `SEQ_CHECKSUM_EN`.
- Defined: `checksum` is cleared at `start` acceptance and XOR-accumulates `result_in` at every RUN edge. Its value is final in the `done` cycle and held until the next `start` or `rst`.
- Undefined: `checksum` is tied to 0 and no accumulator is built; all other behaviour is identical.

## Test plan
- Load bytes 0x05,0x01, 0x25,0x02 → `prog_len`=2. `start` → `instr`=0x0105 then 0x0225 on consecutive cycles. `result_valid` lags by 1 cycle, and `done` pulses 3 cycles after start acceptance.
- Load 2·DEPTH bytes, then offer one more → `load_ready`=0 after the 16th byte, `prog_len`=8, and the extra byte is not accepted.
- Load a single byte, then pulse `start` → no run (`busy`=0). Send the second byte, pulse `start` → run of 1 instruction.
- Drive `result_in`=0x3C, 0x0F, 0xF0 across a 3-instruction run (macro defined) → `checksum`=0xC3 in the `done` cycle. With the macro undefined, `checksum`=0.
- Assert `rst` during the second RUN cycle of a 4-instruction run → `instr_valid`, `busy`, `result_valid` and `done` go to 0 immediately, with `prog_len`=0 and `load_ready`=1.
- `load_clear` and a valid load byte in the same IDLE cycle → `prog_len`=0 and `half`=0, and the byte is dropped. `start` immediately after the run → the identical instruction sequence is replayed.

Source files
------------

// File: rtl/riscv_mini_sequencer.sv
// riscv_mini_sequencer: loads a short program byte-wise, replays it to the
// mini core one instruction per cycle and captures the core result per issue.
// Optional feature macro: SEQ_CHECKSUM_EN (XOR checksum of captured results).
module riscv_mini_sequencer #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_valid,
    input  logic [7:0]               load_byte,
    output logic                     load_ready,
    input  logic                     load_clear,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH):0]   prog_len,
    output logic [15:0]              instr,
    output logic                     instr_valid,
    input  logic [WIDTH-1:0]         result_in,
    output logic [WIDTH-1:0]         result_out,
    output logic                     result_valid,
    output logic [WIDTH-1:0]         checksum
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [15:0]     mem [DEPTH];
    logic [AW-1:0]   wptr, wptr_n;
    logic [LW-1:0]   pc, pc_n;
    logic [LW-1:0]   prog_len_n;
    logic            half, half_n;
    logic [7:0]      low, low_n;
    logic            mem_we;
    logic            load_fire;
    logic            load_ready_n;
    logic            busy_n, done_n, instr_valid_n, result_valid_n;
    logic [15:0]     instr_n;
    logic [WIDTH-1:0] result_out_n;
`ifdef SEQ_CHECKSUM_EN
    logic [WIDTH-1:0] checksum_n;
`endif

    assign load_fire = load_valid && load_ready;

    // Next-state and next-output logic for loading, replay and flush
    always_comb begin
        state_n        = state;
        wptr_n         = wptr;
        pc_n           = pc;
        prog_len_n     = prog_len;
        half_n         = half;
        low_n          = low;
        mem_we         = 1'b0;
        busy_n         = busy;
        done_n         = done;
        instr_n        = instr;
        instr_valid_n  = instr_valid;
        result_out_n   = result_out;
        result_valid_n = result_valid;
`ifdef SEQ_CHECKSUM_EN
        checksum_n     = checksum;
`endif
        case (state)
            IDLE: begin
                if (load_clear) begin
                    wptr_n     = '0;
                    prog_len_n = '0;
                    half_n     = 1'b0;
                end else if (load_fire) begin
                    if (!half) begin
                        low_n  = load_byte;
                        half_n = 1'b1;
                    end else begin
                        mem_we     = 1'b1;
                        wptr_n     = wptr + AW'(1);
                        prog_len_n = prog_len + LW'(1);
                        half_n     = 1'b0;
                    end
                end else if (start && (prog_len != '0) && !half) begin
                    state_n       = RUN;
                    instr_n       = mem[0];
                    instr_valid_n = 1'b1;
                    pc_n          = LW'(1);
                    busy_n        = 1'b1;
`ifdef SEQ_CHECKSUM_EN
                    checksum_n    = '0;
`endif
                end
            end
            RUN: begin
                result_out_n   = result_in;
                result_valid_n = 1'b1;
`ifdef SEQ_CHECKSUM_EN
                checksum_n     = checksum ^ result_in;
`endif
                if (pc < prog_len) begin
                    instr_n = mem[pc[AW-1:0]];
                    pc_n    = pc + LW'(1);
                end else begin
                    instr_valid_n = 1'b0;
                    instr_n       = '0;
                    done_n        = 1'b1;
                    state_n       = FLUSH;
                end
            end
            FLUSH: begin
                result_valid_n = 1'b0;
                done_n         = 1'b0;
                busy_n         = 1'b0;
                state_n        = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        load_ready_n = (state_n == IDLE) && (prog_len_n < LW'(DEPTH));
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            wptr         <= '0;
            pc           <= '0;
            prog_len     <= '0;
            half         <= 1'b0;
            low          <= '0;
            load_ready   <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            instr        <= '0;
            instr_valid  <= 1'b0;
            result_out   <= '0;
            result_valid <= 1'b0;
`ifdef SEQ_CHECKSUM_EN
            checksum     <= '0;
`endif
        end else begin
            state        <= state_n;
            wptr         <= wptr_n;
            pc           <= pc_n;
            prog_len     <= prog_len_n;
            half         <= half_n;
            low          <= low_n;
            load_ready   <= load_ready_n;
            busy         <= busy_n;
            done         <= done_n;
            instr        <= instr_n;
            instr_valid  <= instr_valid_n;
            result_out   <= result_out_n;
            result_valid <= result_valid_n;
`ifdef SEQ_CHECKSUM_EN
            checksum     <= checksum_n;
`endif
        end
    end

`ifndef SEQ_CHECKSUM_EN
    assign checksum = '0;
`endif

    // Instruction buffer write; contents need no reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wptr] <= {load_byte, low};
        end
    end

endmodule
